pwm_pattern_bank: RTL
=====================

PWM_PATTERN_BANK -- requirements
Module: pwm_pattern_bank

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of independent PWM channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the period and duty counters.
REQ-003 SHALL have parameter PAT_WIDTH, default 32, width of the per-channel gating pattern.
REQ-004 SHALL have port sys_clk  in  1  single clock for all logic.
REQ-005 SHALL have port sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid  in  1  configuration write request.
REQ-007 SHALL have port cfg_ready  out  1  configuration write may be accepted.
REQ-008 SHALL have port cfg_ch  in  8  target channel index.
REQ-009 SHALL have port cfg_cmd  in  2  command: 0 = stop, 1 = continuous, 2 = burst, 3 = pattern.
REQ-010 SHALL have port cfg_period  in  CNT_WIDTH  period in clocks.
REQ-011 SHALL have port cfg_duty  in  CNT_WIDTH  high time in clocks.
REQ-012 SHALL have port cfg_pulses  in  8  burst pulse count.
REQ-013 SHALL have port cfg_pat  in  PAT_WIDTH  pattern bits, applied LSB first.
REQ-014 SHALL have port pwm_out  out  NUM_CHANNELS  registered PWM outputs.
REQ-015 SHALL have port pwm_busy  out  NUM_CHANNELS  channel not IDLE.
REQ-016 SHALL have port pwm_valid  out  NUM_CHANNELS  one-cycle pulse when a burst completes.
REQ-017 SHALL have port cfg_err  out  1  one-cycle pulse when a write is rejected.

Function
REQ-018 A write SHALL be accepted on any cycle where cfg_valid && cfg_ready.
REQ-019 An accepted write SHALL capture all cfg_* fields into the target channel's pending shadow and set its pending flag.
REQ-020 cfg_ready SHALL be a registered signal and SHALL be low while any channel's pending flag is set; it SHALL NOT depend on cfg_valid.
REQ-021 If an accepted write has cfg_ch >= NUM_CHANNELS, or has cfg_period == 0 with cfg_cmd != 0:
  - the write SHALL be discarded;
  - cfg_err SHALL pulse on the next cycle;
  - no channel state SHALL change.
REQ-022 Each channel SHALL implement a state machine with states IDLE, RUN, BURST, PATTERN.
REQ-023 A pending write to an IDLE channel SHALL be applied one cycle after acceptance and clear the pending flag.
REQ-024 For a write accepted at cycle T to an IDLE channel, the first pwm_out cycle SHALL appear at T+2.
REQ-025 A pending write to a non-IDLE channel SHALL be applied on the cycle the period counter wraps (cnt == period-1), so no runt pulse is produced.
REQ-026 A stop command (cmd 0) SHALL override REQ-025:
  - it SHALL apply at T+1;
  - pwm_out SHALL be low from T+2;
  - the channel SHALL return to IDLE with no pwm_valid pulse.
REQ-027 The period counter SHALL count 0..period-1 and wrap; the output SHALL be high while cnt < duty.
REQ-028 duty >= period SHALL give a constant high output; duty == 0 SHALL give a constant low output. Both SHALL still count periods.
REQ-029 RUN SHALL repeat periods until a new command is applied.
REQ-030 BURST SHALL emit exactly cfg_pulses periods, pulse pwm_valid for one cycle on the final wrap, then enter IDLE.
REQ-031 BURST with cfg_pulses == 0 SHALL pulse pwm_valid at T+2 and stay IDLE.
REQ-032 PATTERN SHALL gate each period with the current pattern bit:
  - bit 1 gives a normal PWM period; bit 0 gives a low period;
  - the bit index SHALL advance at every wrap and wrap from PAT_WIDTH-1 back to 0;
  - PATTERN SHALL continue until stopped.
REQ-033 pwm_busy SHALL be high in RUN, BURST and PATTERN.
REQ-034 Channels SHALL be independent; simultaneous wraps or completions on several channels SHALL each be handled in the same cycle.

Reset
REQ-035 Asserting sys_rst_n low SHALL asynchronously force:
  - all channels to IDLE;
  - all counters, pattern indices and pending flags to 0;
  - pwm_out, pwm_busy, pwm_valid and cfg_err to 0;
  - cfg_ready to 0.
REQ-036 cfg_ready SHALL rise on the first clock after reset is released.
REQ-037 Reset asserted mid-burst SHALL NOT produce a pwm_valid pulse.

Structure
REQ-038 The command encodings (STOP, RUN, BURST, PATTERN) and the state encodings SHALL be defined as constants in a shared package, pwm_pkg.
REQ-039 The per-channel counter and state machine SHALL be one sub-module, pwm_channel, instantiated NUM_CHANNELS times by a generate loop. The top level SHALL hold only the write decode and the pending logic.

Verification
REQ-040 Continuous: ch0, cmd 1, period 10, duty 3, accepted at T -> pwm_out[0] high T+2..T+4, low T+5..T+11, repeating every 10 cycles.
REQ-041 Burst: ch1, cmd 2, period 4, duty 2, pulses 3 -> three pulses, pwm_valid[1] pulses once at the 12th cycle of output, then pwm_busy[1] = 0.
REQ-042 Pattern: ch2, cmd 3, period 5, duty 5, pat 0x5 with PAT_WIDTH 4 -> periods high, low, high, low, repeating.
REQ-043 Errors: cfg_ch 7 with NUM_CHANNELS 4, and period 0 with cmd 1 -> cfg_err pulses once each, pwm_busy unchanged.
REQ-044 Update and stop: during RUN with period 8, write duty 6 -> change seen only after the wrap; then stop -> pwm_out low 2 cycles after acceptance.
REQ-045 Reset: assert sys_rst_n mid-burst -> all outputs 0 immediately, no pwm_valid, cfg_ready = 1 one clock after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared command and channel-state encodings for the PWM pattern bank.
package pwm_pkg;

  typedef enum logic [1:0] {
    CMD_STOP    = 2'd0,
    CMD_RUN     = 2'd1,
    CMD_BURST   = 2'd2,
    CMD_PATTERN = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BURST   = 2'd2,
    ST_PATTERN = 2'd3
  } state_t;

  localparam int CH_IDX_W = 8;
  localparam int PULSE_W  = 8;

endpackage

// File: rtl/pwm_pattern_bank_if.sv
// Configuration write channel: valid/ready request with per-field payload and a reject pulse.
interface pwm_pattern_bank_if #(
  parameter int CNT_WIDTH = 16,
  parameter int PAT_WIDTH = 32
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [7:0]           cfg_ch;
  logic [1:0]           cfg_cmd;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic [CNT_WIDTH-1:0] cfg_duty;
  logic [7:0]           cfg_pulses;
  logic [PAT_WIDTH-1:0] cfg_pat;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_cmd, cfg_period, cfg_duty, cfg_pulses, cfg_pat,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_cmd, cfg_period, cfg_duty, cfg_pulses, cfg_pat,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: period counter plus IDLE/RUN/BURST/PATTERN FSM; outputs are registered
// from next-cycle values so pwm_out/valid line up with the counter value of the same cycle.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int PAT_WIDTH = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 pend,
  input  cmd_t                 cmd,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] duty,
  input  logic [PULSE_W-1:0]   pulses,
  input  logic [PAT_WIDTH-1:0] pat,
  output logic                 apply,
  output logic                 out,
  output logic                 busy,
  output logic                 valid
);
  localparam int IDX_W = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] per_q;
  logic [CNT_WIDTH-1:0] duty_q;
  logic [PULSE_W-1:0]   left;
  logic [PAT_WIDTH-1:0] pat_q;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_inc;
  logic                 wrap;
  logic                 gate;

  assign wrap    = (state != ST_IDLE) && (cnt == per_q - CNT_WIDTH'(1));
  // Stop bypasses the wrap wait; anything else waits so no runt pulse is emitted.
  assign apply   = pend && ((state == ST_IDLE) || (cmd == CMD_STOP) || wrap);
  assign cnt_inc = cnt + CNT_WIDTH'(1);
  assign idx_inc = (idx == IDX_W'(PAT_WIDTH - 1)) ? '0 : idx + IDX_W'(1);
  assign gate    = (state != ST_PATTERN) || pat_q[idx];
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      per_q  <= '0;
      duty_q <= '0;
      left   <= '0;
      pat_q  <= '0;
      idx    <= '0;
      out    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (apply) begin
        cnt    <= '0;
        idx    <= '0;
        per_q  <= period;
        duty_q <= duty;
        pat_q  <= pat;
        left   <= pulses;
        case (cmd)
          CMD_RUN: begin
            state <= ST_RUN;
            out   <= (duty != '0);
          end
          CMD_BURST: begin
            if (pulses == '0) begin
              state <= ST_IDLE;
              out   <= 1'b0;
              valid <= 1'b1;
            end else begin
              state <= ST_BURST;
              out   <= (duty != '0);
              valid <= (pulses == PULSE_W'(1)) && (period == CNT_WIDTH'(1));
            end
          end
          CMD_PATTERN: begin
            state <= ST_PATTERN;
            out   <= pat[0] && (duty != '0);
          end
          default: begin
            state <= ST_IDLE;
            out   <= 1'b0;
          end
        endcase
      end else if (wrap) begin
        cnt <= '0;
        case (state)
          ST_BURST: begin
            if (left == PULSE_W'(1)) begin
              state <= ST_IDLE;
              out   <= 1'b0;
            end else begin
              left  <= left - PULSE_W'(1);
              out   <= (duty_q != '0);
              valid <= (left == PULSE_W'(2)) && (per_q == CNT_WIDTH'(1));
            end
          end
          ST_PATTERN: begin
            idx <= idx_inc;
            out <= pat_q[idx_inc] && (duty_q != '0);
          end
          default: out <= (duty_q != '0);
        endcase
      end else if (state != ST_IDLE) begin
        cnt   <= cnt_inc;
        out   <= gate && (cnt_inc < duty_q);
        // Flag lands on the last cycle of the final burst period.
        valid <= (state == ST_BURST) && (left == PULSE_W'(1)) &&
                 (cnt_inc == per_q - CNT_WIDTH'(1));
      end else begin
        out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_pattern_bank.sv
// Bank of independent PWM channels: write decode, per-channel pending shadows and
// registered ready/error; the channels themselves live in pwm_channel.
module pwm_pattern_bank
  import pwm_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int PAT_WIDTH    = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  pwm_pattern_bank_if.slave       cfg,
  output logic [NUM_CHANNELS-1:0] pwm_out,
  output logic [NUM_CHANNELS-1:0] pwm_busy,
  output logic [NUM_CHANNELS-1:0] pwm_valid
);
  logic                    accept;
  logic                    bad;
  logic                    ready_q;
  logic                    err_q;
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] pending_nxt;
  logic [NUM_CHANNELS-1:0] hit;
  logic [NUM_CHANNELS-1:0] apply;

  cmd_t                 sh_cmd    [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0] sh_period [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0] sh_duty   [NUM_CHANNELS];
  logic [PULSE_W-1:0]   sh_pulses [NUM_CHANNELS];
  logic [PAT_WIDTH-1:0] sh_pat    [NUM_CHANNELS];

  assign accept        = cfg.cfg_valid && ready_q;
  assign bad           = (cfg.cfg_ch >= CH_IDX_W'(NUM_CHANNELS)) ||
                         ((cfg.cfg_period == '0) && (cfg.cfg_cmd != CMD_STOP));
  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      hit[i] = accept && !bad && (cfg.cfg_ch == CH_IDX_W'(i));
    end
    pending_nxt = (pending & ~apply) | hit;
  end

  // Ready looks ahead at the pending flags so it drops on the acceptance edge itself.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      ready_q <= ~|pending_nxt;
      err_q   <= accept && bad;
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (hit[i]) begin
        sh_cmd[i]    <= cmd_t'(cfg.cfg_cmd);
        sh_period[i] <= cfg.cfg_period;
        sh_duty[i]   <= cfg.cfg_duty;
        sh_pulses[i] <= cfg.cfg_pulses;
        sh_pat[i]    <= cfg.cfg_pat;
      end
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .PAT_WIDTH (PAT_WIDTH)
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pend      (pending[g]),
      .cmd       (sh_cmd[g]),
      .period    (sh_period[g]),
      .duty      (sh_duty[g]),
      .pulses    (sh_pulses[g]),
      .pat       (sh_pat[g]),
      .apply     (apply[g]),
      .out       (pwm_out[g]),
      .busy      (pwm_busy[g]),
      .valid     (pwm_valid[g])
    );
  end

endmodule
